// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE pending-bit write scheduler.
//   - scheduler state encoding
//   - declare macro for the pending-write entry, so the FIFO payload, the
//     ucode request and the output register all use one layout for a given
//     physical address width.

`ifndef BP_CCE_PKG_SV
`define BP_CCE_PKG_SV

`define BP_CCE_DECLARE_PENDING_W_S(addr_width_mp) \
  typedef struct packed {                          \
    logic [addr_width_mp-1:0] addr;                \
    logic                     addr_bypass;         \
    logic                     pending;             \
  } bp_cce_pending_w_s

package bp_cce_pkg;

  typedef enum logic [0:0] {
    e_pend_ready = 1'b0,
    e_pend_drain = 1'b1
  } bp_cce_pend_sched_state_e;

  // Width of a pending-write entry for a given address width.
  function automatic int pending_w_width(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

`endif

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read/one-write FIFO with valid/ready on the write side and
// valid/yumi on the read side. ready_o comes only from the registered
// occupancy, so a dequeue in the same cycle never frees a slot for an
// enqueue in that cycle.

module bsg_fifo_1r1w_small #(
  parameter int els_p   = 2,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                enq, deq;

  assign ready_o = (count_r != cnt_w_lp'(els_p));
  assign v_o     = (count_r != '0);
  assign data_o  = mem[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy tracking; cleared asynchronously so reset discards
  // any queued entries.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_cce_pending_w_sched.sv
// Pending-bit write scheduler between the message unit (auto-forward) and
// ucode. Msg writes queue in a small FIFO; one write per cycle is chosen and
// registered toward the pending-bit array. The FIFO head wins by default.
//
// Optional feature macro: BP_CCE_PENDING_STARVE_GUARD_EN
//   defined   -> a saturating counter forces a ucode grant after
//                starve_limit_p consecutive lost ucode cycles.
//   undefined -> msg always wins; ucode waits for an empty FIFO.

module bp_cce_pending_w_sched
  import bp_cce_pkg::*;
#(
  parameter int paddr_width_p  = 40,
  parameter int fifo_els_p     = 2,
  parameter int starve_limit_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     stall_i,
  input  logic                     ucode_v_i,
  input  logic [paddr_width_p-1:0] ucode_addr_i,
  input  logic                     ucode_bypass_i,
  input  logic                     ucode_pending_i,
  output logic                     ucode_yumi_o,
  input  logic                     msg_v_i,
  output logic                     msg_ready_o,
  input  logic [paddr_width_p-1:0] msg_addr_i,
  input  logic                     msg_bypass_i,
  input  logic                     msg_pending_i,
  input  logic                     drain_i,
  output logic                     drained_o,
  output logic                     pending_w_v_o,
  output logic [paddr_width_p-1:0] pending_w_addr_o,
  output logic                     pending_w_addr_bypass_o,
  output logic                     pending_o
);

  `BP_CCE_DECLARE_PENDING_W_S(paddr_width_p);

  localparam int entry_width_lp = pending_w_width(paddr_width_p);

  bp_cce_pend_sched_state_e state_r, state_n;
  bp_cce_pending_w_s        msg_in, ucode_in, head, sel, out_r;
  logic [entry_width_lp-1:0] head_raw;
  logic fifo_ready, fifo_v, fifo_yumi, enq_v;
  logic in_ready, ucode_cand, ucode_grant, starve_force, any_grant;

  assign msg_in   = '{addr: msg_addr_i,   addr_bypass: msg_bypass_i,   pending: msg_pending_i};
  assign ucode_in = '{addr: ucode_addr_i, addr_bypass: ucode_bypass_i, pending: ucode_pending_i};
  assign head     = bp_cce_pending_w_s'(head_raw);

  // Comb outputs are gated by reset so every output reads 0 while it is held.
  assign in_ready    = ~reset_i & (state_r == e_pend_ready);
  assign msg_ready_o = in_ready & fifo_ready;
  assign enq_v       = msg_v_i & msg_ready_o;

  bsg_fifo_1r1w_small #(
    .els_p  (fifo_els_p),
    .width_p(entry_width_lp)
  ) msg_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (enq_v),
    .data_i (msg_in),
    .ready_o(fifo_ready),
    .v_o    (fifo_v),
    .data_o (head_raw),
    .yumi_i (fifo_yumi)
  );

  // Ucode is only a candidate in READY; in DRAIN the head goes every cycle.
  assign ucode_cand   = in_ready & ucode_v_i & ~stall_i;
  assign ucode_grant  = ucode_cand & (~fifo_v | starve_force);
  assign fifo_yumi    = fifo_v & ~ucode_grant;
  assign ucode_yumi_o = ucode_grant;
  assign any_grant    = ucode_grant | fifo_yumi;

`ifdef BP_CCE_PENDING_STARVE_GUARD_EN
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  logic [starve_w_lp-1:0] starve_cnt_r;

  assign starve_force = (starve_cnt_r == starve_w_lp'(starve_limit_p));

  // Count consecutive cycles a ucode candidate loses; clear on grant or idle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_cnt_r <= '0;
    end else if (ucode_cand & ~ucode_grant) begin
      if (!starve_force) starve_cnt_r <= starve_cnt_r + 1'b1;
    end else begin
      starve_cnt_r <= '0;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // Drain completes in the DRAIN cycle that finds the FIFO empty.
  assign drained_o = (state_r == e_pend_drain) & ~fifo_v;

  // Next-state: drain_i only matters in READY.
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_pend_ready: if (drain_i) state_n = e_pend_drain;
      e_pend_drain: if (!fifo_v) state_n = e_pend_ready;
      default:      state_n = e_pend_ready;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= e_pend_ready;
    else         state_r <= state_n;
  end

  // Winner's payload; zero when nothing is granted.
  always_comb begin
    sel = '0;
    if (ucode_grant)    sel = ucode_in;
    else if (fifo_yumi) sel = head;
  end

  // Registered write toward the pending-bit array.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pending_w_v_o <= 1'b0;
      out_r         <= '0;
    end else begin
      pending_w_v_o <= any_grant;
      out_r         <= sel;
    end
  end

  assign pending_w_addr_o        = out_r.addr;
  assign pending_w_addr_bypass_o = out_r.addr_bypass;
  assign pending_o               = out_r.pending;

endmodule
